// File: rtl/sram_stream_ctrl_pkg.sv
// Shared constants and state encoding for the SRAM stream controller.
// Holds WORD_WIDTH/ADDR_WIDTH defaults and the FSM state type.
package sram_stream_ctrl_pkg;

    localparam int WORD_WIDTH_DEF = 256;
    localparam int ADDR_WIDTH_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

endpackage

// File: rtl/sram_stream_ctrl_if.sv
// Write/read stream bundle between a producer/consumer and the controller.
// slave: controller side; master: producer/consumer side.
interface sram_stream_ctrl_if
    import sram_stream_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF
) ();

    logic                  wr_valid;
    logic                  wr_ready;
    logic [WORD_WIDTH-1:0] wr_data;
    logic                  wr_last;
    logic                  rd_start;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [WORD_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic                  busy;

    modport slave (
        input  wr_valid, wr_data, wr_last, rd_start, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_last, busy
    );

    modport master (
        output wr_valid, wr_data, wr_last, rd_start, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_last, busy
    );

endinterface

// File: rtl/sram_rd_fifo.sv
// Two-entry output FIFO for SRAM read data.
// Ports: push/data_in in, pop in, data_out head, count/full/empty status.
module sram_rd_fifo #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_idx_q, wr_idx_d;
    logic             rd_idx_q, rd_idx_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign count    = count_q;
    assign data_out = mem_q[rd_idx_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_idx_d = wr_idx_q ^ do_push;
        rd_idx_d = rd_idx_q ^ do_pop;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_idx_q] <= data_in;
    end

endmodule

// File: rtl/sram_stream_ctrl.sv
// Captures a write burst into single-port SRAM and replays it as a stream.
// Ports: clk, rst_n, stream bundle s (slave), sram_cen/wen/addr/d out, sram_q in.
module sram_stream_ctrl
    import sram_stream_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_stream_ctrl_if.slave     s,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [WORD_WIDTH-1:0] sram_d,
    input  logic [WORD_WIDTH-1:0] sram_q
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   pop_cnt_q, pop_cnt_d;
    logic                  inflight_q, inflight_d;

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  start_rd, wr_ready, wr_hs, wr_end;
    logic                  pop, rd_last, room, issue;
    logic [1:0]            f_count;
    logic                  f_full, f_empty;

    sram_rd_fifo #(.WIDTH(WORD_WIDTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight_q),
        .pop      (pop),
        .data_in  (sram_q),
        .data_out (s.rd_data),
        .count    (f_count),
        .full     (f_full),
        .empty    (f_empty)
    );

    // A burst started from IDLE always begins at address 0.
    assign wr_addr  = (state_q == ST_IDLE) ? '0 : wr_ptr_q;
    assign start_rd = (state_q == ST_IDLE) && s.rd_start && (len_q != '0);
    assign wr_ready = rst_n && !start_rd &&
                      ((state_q == ST_IDLE) || (state_q == ST_WRITE));
    assign wr_hs    = s.wr_valid & wr_ready;
    assign wr_end   = s.wr_last | (wr_addr == '1);

    assign pop      = ~f_empty & s.rd_ready;
    assign rd_last  = ~f_empty && (pop_cnt_q == len_q - 1'b1);

    // Keep fifo entries plus the read in flight within two slots.
    assign room     = pop ? !(f_full && inflight_q)
                          : (({1'b0, f_count} + {2'b0, inflight_q}) < 3'd2);
    assign issue    = (state_q == ST_READ) && (rd_ptr_q < len_q) && room;

    assign s.wr_ready = wr_ready;
    assign s.rd_valid = ~f_empty;
    assign s.rd_last  = rd_last;
    assign s.busy     = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        len_d      = len_q;
        pop_cnt_d  = pop_cnt_q;
        inflight_d = issue;
        unique case (state_q)
            ST_IDLE, ST_WRITE: begin
                if (start_rd) begin
                    state_d   = ST_READ;
                    rd_ptr_d  = '0;
                    pop_cnt_d = '0;
                end else if (wr_hs) begin
                    if (wr_end) begin
                        len_d    = {1'b0, wr_addr} + 1'b1;
                        wr_ptr_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        len_d    = '0;
                        wr_ptr_d = wr_addr + 1'b1;
                        state_d  = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
                if (pop) begin
                    pop_cnt_d = pop_cnt_q + 1'b1;
                    if (rd_last) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_addr = '0;
        sram_d    = '0;
        if (wr_hs) begin
            sram_cen  = 1'b0;
            sram_wen  = 1'b0;
            sram_addr = wr_addr;
            sram_d    = s.wr_data;
        end else if (issue) begin
            sram_cen  = 1'b0;
            sram_addr = rd_ptr_q[ADDR_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            len_q      <= '0;
            pop_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            len_q      <= len_d;
            pop_cnt_q  <= pop_cnt_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_sram_stream_ctrl.sv
// Directed bench for sram_stream_ctrl with SRAM models and a scoreboard.
// Instance a uses ADDR_WIDTH=10, instance b uses ADDR_WIDTH=3.
module tb_sram_stream_ctrl;

    localparam int WW = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          sel;
    logic          wr_valid, wr_last, rd_start, rd_ready;
    logic [WW-1:0] wr_data;

    sram_stream_ctrl_if #(.WORD_WIDTH(WW)) if_a ();
    sram_stream_ctrl_if #(.WORD_WIDTH(WW)) if_b ();

    assign if_a.wr_valid = wr_valid & ~sel;
    assign if_a.rd_start = rd_start & ~sel;
    assign if_a.wr_data  = wr_data;
    assign if_a.wr_last  = wr_last;
    assign if_a.rd_ready = rd_ready;
    assign if_b.wr_valid = wr_valid & sel;
    assign if_b.rd_start = rd_start & sel;
    assign if_b.wr_data  = wr_data;
    assign if_b.wr_last  = wr_last;
    assign if_b.rd_ready = rd_ready;

    logic          cen_a, wen_a, cen_b, wen_b;
    logic [9:0]    addr_a;
    logic [2:0]    addr_b;
    logic [WW-1:0] d_a, d_b, q_a, q_b;
    logic [WW-1:0] mem_a [1024];
    logic [WW-1:0] mem_b [8];

    sram_stream_ctrl #(.WORD_WIDTH(WW), .ADDR_WIDTH(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .s(if_a),
        .sram_cen(cen_a), .sram_wen(wen_a), .sram_addr(addr_a),
        .sram_d(d_a), .sram_q(q_a)
    );

    sram_stream_ctrl #(.WORD_WIDTH(WW), .ADDR_WIDTH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .s(if_b),
        .sram_cen(cen_b), .sram_wen(wen_b), .sram_addr(addr_b),
        .sram_d(d_b), .sram_q(q_b)
    );

    always @(posedge clk) begin
        if (!cen_a) begin
            if (!wen_a) mem_a[addr_a] <= d_a;
            else        q_a <= mem_a[addr_a];
        end
        if (!cen_b) begin
            if (!wen_b) mem_b[addr_b] <= d_b;
            else        q_b <= mem_b[addr_b];
        end
    end

    logic          c_rd_valid, c_rd_last, c_busy, c_wr_ready, c_cen, c_wen;
    logic [WW-1:0] c_rd_data;
    logic [9:0]    c_addr;

    assign c_rd_valid = sel ? if_b.rd_valid : if_a.rd_valid;
    assign c_rd_last  = sel ? if_b.rd_last  : if_a.rd_last;
    assign c_rd_data  = sel ? if_b.rd_data  : if_a.rd_data;
    assign c_busy     = sel ? if_b.busy     : if_a.busy;
    assign c_wr_ready = sel ? if_b.wr_ready : if_a.wr_ready;
    assign c_cen      = sel ? cen_b : cen_a;
    assign c_wen      = sel ? wen_b : wen_a;
    assign c_addr     = sel ? {7'd0, addr_b} : addr_a;

    int iss_cnt = 0;
    int pop_cnt = 0;
    always @(posedge clk) begin
        if (!c_cen && c_wen) iss_cnt <= iss_cnt + 1;
        if (c_rd_valid && rd_ready) pop_cnt <= pop_cnt + 1;
    end

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    logic [WW-1:0] sb_q [$];
    logic [WW-1:0] burst [$];

    task automatic chk(input string tag, input logic [WW-1:0] obs,
                       input logic [WW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [WW-1:0] d, input bit last,
                              input logic [9:0] exp_addr);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        #1;
        chk("wr_ready", c_wr_ready, 1);
        chk("wr_cen", c_cen, 0);
        chk("wr_wen", c_wen, 0);
        chk("wr_addr", c_addr, exp_addr);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        rd_start = 1'b0;
        #1;
    endtask

    task automatic read_burst(input int n, input logic [3:0] pat,
                              input bit with_wr);
        int got, first, iss0, pop0, outst;
        bit stalled;
        logic [WW-1:0] held, exp;
        got = 0; first = 0; stalled = 0; held = '0;
        iss0 = iss_cnt; pop0 = pop_cnt;
        @(negedge clk);
        rd_start = 1'b1;
        if (with_wr) begin
            wr_valid = 1'b1;
            wr_data  = 256'hFF;
            wr_last  = 1'b1;
            #1;
            chk("coincide_wr_ready", c_wr_ready, 0);
            chk("coincide_wen", c_wen, 1);
        end
        for (int c = 1; c <= 200 && got < n; c++) begin
            @(negedge clk);
            rd_start = 1'b0;
            wr_valid = 1'b0;
            wr_last  = 1'b0;
            rd_ready = pat[c % 4];
            #1;
            outst = (iss_cnt - iss0) - (pop_cnt - pop0);
            chk("outstanding_le2", (outst <= 2), 1);
            if (c_rd_valid) begin
                if (first == 0) begin
                    first = c;
                    chk("first_latency", c, 3);
                end
                if (stalled) chk("stall_hold", c_rd_data, held);
                if (rd_ready) begin
                    exp = sb_q.pop_front();
                    chk("rd_data", c_rd_data, exp);
                    chk("rd_last", c_rd_last, (got == n - 1));
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = c_rd_data;
                end
            end
        end
        if (got < n) chk("read_timeout", got, n);
        @(negedge clk);
        rd_ready = 1'b0;
        #1;
        chk("busy_after_read", c_busy, 0);
        chk("rd_valid_after_read", c_rd_valid, 0);
    endtask

    initial begin
        bit hit;
        sel = 1'b0;
        rst_n = 1'b0;
        wr_valid = 1'b1;
        wr_last = 1'b0;
        rd_start = 1'b0;
        rd_ready = 1'b0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd_valid", if_a.rd_valid, 0);
        chk("rst_rd_last", if_a.rd_last, 0);
        chk("rst_busy", if_a.busy, 0);
        chk("rst_cen", cen_a, 1);
        chk("rst_wen", wen_a, 1);
        chk("rst_b_cen", cen_b, 1);
        wr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_wr_ready", if_a.wr_ready, 1);

        @(negedge clk);
        rd_start = 1'b1;
        repeat (3) begin
            idle_cycle();
            chk("len0_rd_valid", c_rd_valid, 0);
            chk("len0_busy", c_busy, 0);
        end

        burst = {256'hA0, 256'hA1, 256'hA2, 256'hA3};
        write_word(burst[0], 0, 0);
        write_word(burst[1], 0, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        rd_start = 1'b1;
        #1;
        chk("write_busy", c_busy, 1);
        repeat (3) begin
            idle_cycle();
            chk("inwrite_rd_valid", c_rd_valid, 0);
            chk("inwrite_busy", c_busy, 1);
        end
        write_word(burst[2], 0, 2);
        write_word(burst[3], 1, 3);
        idle_cycle();
        chk("burst_done_busy", c_busy, 0);

        foreach (burst[i]) sb_q.push_back(burst[i]);
        read_burst(4, 4'b1111, 0);
        foreach (burst[i]) sb_q.push_back(burst[i]);
        read_burst(4, 4'b0011, 0);
        foreach (burst[i]) sb_q.push_back(burst[i]);
        read_burst(4, 4'b1111, 1);

        sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            write_word(256'hB0 + 256'(i), 0, 10'(i));
        end
        idle_cycle();
        chk("forced_last_idle", c_busy, 0);
        for (int i = 0; i < 8; i++) sb_q.push_back(256'hB0 + 256'(i));
        read_burst(8, 4'b1111, 0);
        write_word(256'hB8, 0, 0);
        idle_cycle();
        chk("new_burst_busy", c_busy, 1);
        write_word(256'hB9, 1, 1);
        idle_cycle();
        chk("new_burst_done", c_busy, 0);
        sb_q.push_back(256'hB8);
        sb_q.push_back(256'hB9);
        read_burst(2, 4'b1111, 0);

        sel = 1'b0;
        @(negedge clk);
        rd_start = 1'b1;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            rd_start = 1'b0;
            rd_ready = 1'b1;
            #1;
            if (c_rd_valid && c_rd_data == 256'hA2) hit = 1;
        end
        chk("reach_word2", hit, 1);
        rst_n = 1'b0;
        #1;
        chk("midrd_rst_rd_valid", c_rd_valid, 0);
        chk("midrd_rst_rd_last", c_rd_last, 0);
        chk("midrd_rst_busy", c_busy, 0);
        chk("midrd_rst_cen", c_cen, 1);
        chk("midrd_rst_wen", c_wen, 1);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rd_ready = 1'b0;
        @(negedge clk);
        rd_start = 1'b1;
        repeat (4) begin
            idle_cycle();
            chk("post_rst_rd_valid", c_rd_valid, 0);
            chk("post_rst_busy", c_busy, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sram_stream_ctrl.md
SRAM_STREAM_CTRL -- requirements
Module: sram_stream_ctrl

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 256: SRAM word and stream data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: SRAM address width; DEPTH = 2^ADDR_WIDTH.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_valid  in  1  write-stream word valid.
REQ-006 SHALL have port wr_ready  out  1  write-stream word accepted when high with wr_valid.
REQ-007 SHALL have port wr_data  in  WORD_WIDTH  write-stream word.
REQ-008 SHALL have port wr_last  in  1  marks final word of the write burst.
REQ-009 SHALL have port rd_start  in  1  single-cycle request to replay the stored burst.
REQ-010 SHALL have port rd_valid  out  1  read-stream word valid.
REQ-011 SHALL have port rd_ready  in  1  read-stream consumer ready.
REQ-012 SHALL have port rd_data  out  WORD_WIDTH  read-stream word.
REQ-013 SHALL have port rd_last  out  1  high with the final read word.
REQ-014 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-015 SHALL have ports sram_cen (out 1, active low), sram_wen (out 1, active low write), sram_addr (out ADDR_WIDTH), sram_d (out WORD_WIDTH), sram_q (in WORD_WIDTH; valid one cycle after a read issue).

Function
REQ-016 FSM states SHALL be IDLE, WRITE, READ.
REQ-017 wr_ready SHALL be 1 in IDLE and WRITE, 0 in READ; a write handshake is wr_valid & wr_ready.
REQ-018 Each write handshake SHALL drive sram_cen=0, sram_wen=0, sram_addr=wr_ptr, sram_d=wr_data in the same cycle, then increment wr_ptr.
REQ-019 A handshake in IDLE SHALL start a new burst at address 0 (discarding the stored length) and enter WRITE unless it also carries wr_last.
REQ-020 A handshake with wr_last, or on address DEPTH-1 (forced last), SHALL store len = address+1 (ADDR_WIDTH+1 bits), reset wr_ptr to 0, and enter IDLE.
REQ-021 rd_start in IDLE with len>0 SHALL enter READ with rd_ptr=0; rd_start is ignored in WRITE, READ, or when len=0; if rd_start and wr_valid coincide in IDLE with len>0, rd_start SHALL win (wr_ready=0 that cycle).
REQ-022 In READ the block SHALL issue a read (sram_cen=0, sram_wen=1, sram_addr=rd_ptr) whenever rd_ptr<len and fifo_count + inflight - pop < 2, incrementing rd_ptr.
REQ-023 sram_q SHALL be pushed into a 2-entry output FIFO on the cycle after each issue; rd_valid = FIFO non-empty, rd_data = FIFO head.
REQ-024 First rd_valid SHALL rise 2 cycles after the edge sampling rd_start; with rd_ready held high throughput SHALL be 1 word/cycle.
REQ-025 rd_valid/rd_data SHALL stay stable while rd_valid & ~rd_ready; no word dropped or duplicated.
REQ-026 rd_last SHALL be high exactly with word index len-1; its handshake SHALL return FSM to IDLE; len is retained, so replay is repeatable.
REQ-027 Idle cycles SHALL drive sram_cen=1, sram_wen=1.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, wr_ptr=rd_ptr=0, len=0, FIFO empty, inflight=0, rd_valid=0, rd_last=0, busy=0, sram_cen=1, sram_wen=1, wr_ready=1 after release.
REQ-029 Reset mid-WRITE or mid-READ SHALL abandon the burst; no partial len stored.

Structure
REQ-030 WORD_WIDTH/ADDR_WIDTH defaults and state encodings SHALL live in the shared define header.
REQ-031 The 2-entry output FIFO SHALL be a sub-module sram_rd_fifo (push, pop, data, count, full, empty).

Verification
REQ-032 Write 4 words 0xA0..0xA3 (wr_last on 0xA3), rd_start, rd_ready=1 -> rd_data 0xA0..0xA3 on consecutive cycles, first 2 cycles after rd_start, rd_last with 0xA3, busy falls after.
REQ-033 Same burst, rd_ready toggled 1,0,0,1,... -> each word held stable while stalled, order intact, never >2 reads outstanding.
REQ-034 ADDR_WIDTH=3, stream 9 words without wr_last -> 8th word forces len=8, IDLE; 9th word starts new burst at address 0.
REQ-035 rd_start after reset (len=0), and rd_start during WRITE -> ignored, rd_valid stays 0.
REQ-036 rd_start and wr_valid same cycle in IDLE with len=4 -> READ entered, word not accepted.
REQ-037 rst_n low during READ word 2 -> all outputs at reset values at once; subsequent rd_start ignored (len=0).
